// File: rtl/mfcc_frame_packer_pkg.sv
// Shared types and helpers for the keyword-spotting feature path.
// State encoding and saturation bounds are reused by the later conv stages.
package mfcc_frame_packer_pkg;

  localparam int NUM_FEATURES_DEF = 40;
  localparam int ACTIV_BITS_DEF   = 16;

  typedef enum logic [1:0] {
    COLLECT   = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  // Bounds of a signed two's-complement value of the given width, held wide enough for any stage.
  function automatic logic signed [63:0] satHigh(input int unsigned bits);
    satHigh = (64'sd1 <<< (bits - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] satLow(input int unsigned bits);
    satLow = -(64'sd1 <<< (bits - 1));
  endfunction

endpackage

// File: rtl/mfcc_frame_packer_sat_shift.sv
// Arithmetic right shift followed by signed saturation to OUT_BITS.
// Purely combinational; o_sat flags that the result was clamped.
module sat_shift
  import mfcc_frame_packer_pkg::*;
#(
  parameter int IN_BITS  = 24,
  parameter int OUT_BITS = ACTIV_BITS_DEF,
  parameter int SHIFT    = 8
) (
  input  logic signed [IN_BITS-1:0]  i_value,
  output logic        [OUT_BITS-1:0] o_value,
  output logic                       o_sat
);

  logic signed [IN_BITS-1:0] w_shifted;
  logic signed [63:0]        w_wide;

  assign w_shifted = i_value >>> SHIFT;
  assign w_wide    = {{(64 - IN_BITS){w_shifted[IN_BITS-1]}}, w_shifted};

  always_comb begin
    o_sat   = 1'b0;
    o_value = w_wide[OUT_BITS-1:0];
    if (w_wide > satHigh(OUT_BITS)) begin
      o_sat   = 1'b1;
      o_value = {1'b0, {(OUT_BITS - 1){1'b1}}};
    end else if (w_wide < satLow(OUT_BITS)) begin
      o_sat   = 1'b1;
      o_value = {1'b1, {(OUT_BITS - 1){1'b0}}};
    end
  end

endmodule

// File: rtl/mfcc_frame_packer.sv
// Packs a serial stream of MFCC coefficients into one wide frame for the conv stage,
// pulses frame_valid once per complete frame and stalls the extractor until conv_done.
module mfcc_frame_packer
  import mfcc_frame_packer_pkg::*;
#(
  parameter int NUM_FEATURES = NUM_FEATURES_DEF,
  parameter int IN_BITS      = 24,
  parameter int ACTIV_BITS   = ACTIV_BITS_DEF,
  parameter int SHIFT        = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic signed [IN_BITS-1:0]          i_feat_in,
  input  logic                               i_feat_valid,
  input  logic                               i_frame_start,
  output logic                               o_feat_ready,
  output logic [NUM_FEATURES*ACTIV_BITS-1:0] o_frame_out,
  output logic                               o_frame_valid,
  output logic                               o_frame_sat,
  input  logic                               i_conv_done,
  output logic                               o_frame_err,
  output logic                               o_busy
);

  localparam int CNT_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_FEATURES - 1);

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        w_countNext;
  logic [CNT_W-1:0]        w_slot;
  logic                    w_write;
  logic                    r_sat;
  logic                    w_satNext;
  logic                    r_frameErr;
  logic                    w_frameErrNext;
  logic                    w_accept;
  logic [ACTIV_BITS-1:0]   w_coef;
  logic                    w_coefSat;
  logic [ACTIV_BITS-1:0]   r_slots [NUM_FEATURES];

  sat_shift #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (ACTIV_BITS),
    .SHIFT    (SHIFT)
  ) u_sat_shift (
    .i_value (i_feat_in),
    .o_value (w_coef),
    .o_sat   (w_coefSat)
  );

  assign o_feat_ready  = (r_state == COLLECT);
  assign o_frame_valid = (r_state == ISSUE);
  assign o_busy        = (r_state == ISSUE) || (r_state == WAIT_DONE);
  assign o_frame_sat   = r_sat;
  assign o_frame_err   = r_frameErr;
  assign w_accept      = i_feat_valid & o_feat_ready;

  always_comb begin
    for (int k = 0; k < NUM_FEATURES; k++) begin
      o_frame_out[k*ACTIV_BITS +: ACTIV_BITS] = r_slots[k];
    end
  end

  // frame_start always restarts at slot 0; a mid-frame restart abandons the partial frame.
  always_comb begin
    w_stateNext    = r_state;
    w_countNext    = r_count;
    w_slot         = r_count;
    w_write        = 1'b0;
    w_satNext      = r_sat;
    w_frameErrNext = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_accept) begin
          if (i_frame_start) begin
            w_write        = 1'b1;
            w_slot         = '0;
            w_satNext      = w_coefSat;
            w_frameErrNext = (r_count != '0);
          end else if (r_count == '0) begin
            w_frameErrNext = 1'b1;
          end else begin
            w_write   = 1'b1;
            w_satNext = r_sat | w_coefSat;
          end
          if (w_write) begin
            if (w_slot == LAST_SLOT) begin
              w_stateNext = ISSUE;
              w_countNext = '0;
            end else begin
              w_countNext = w_slot + CNT_W'(1);
            end
          end
        end
      end
      ISSUE: begin
        w_stateNext = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_conv_done) begin
          w_stateNext = COLLECT;
        end
      end
      default: begin
        w_stateNext = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= COLLECT;
      r_count    <= '0;
      r_sat      <= 1'b0;
      r_frameErr <= 1'b0;
      for (int k = 0; k < NUM_FEATURES; k++) begin
        r_slots[k] <= '0;
      end
    end else begin
      r_state    <= w_stateNext;
      r_count    <= w_countNext;
      r_sat      <= w_satNext;
      r_frameErr <= w_frameErrNext;
      if (w_write) begin
        r_slots[w_slot] <= w_coef;
      end
    end
  end

endmodule

// File: tb/tb_mfcc_frame_packer.sv
// Directed bench for mfcc_frame_packer: default instance for framing/flow control,
// a single-coefficient instance with SHIFT=4 for saturation corner cases.
module tb_mfcc_frame_packer;

  logic          clk;
  logic          rst_n;
  logic [23:0]   featIn;
  logic          featValid;
  logic          frameStart;
  logic          featReady;
  logic [639:0]  frameOut;
  logic          frameValid;
  logic          frameSat;
  logic          convDone;
  logic          frameErr;
  logic          busy;

  logic [23:0]   bFeatIn;
  logic          bFeatValid;
  logic          bFrameStart;
  logic          bFeatReady;
  logic [15:0]   bFrameOut;
  logic          bFrameValid;
  logic          bFrameSat;
  logic          bConvDone;
  logic          bFrameErr;
  logic          bBusy;

  int checks;
  int failures;

  mfcc_frame_packer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_feat_in     (featIn),
    .i_feat_valid  (featValid),
    .i_frame_start (frameStart),
    .o_feat_ready  (featReady),
    .o_frame_out   (frameOut),
    .o_frame_valid (frameValid),
    .o_frame_sat   (frameSat),
    .i_conv_done   (convDone),
    .o_frame_err   (frameErr),
    .o_busy        (busy)
  );

  mfcc_frame_packer #(
    .NUM_FEATURES (1),
    .IN_BITS      (24),
    .ACTIV_BITS   (16),
    .SHIFT        (4)
  ) dutSingle (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_feat_in     (bFeatIn),
    .i_feat_valid  (bFeatValid),
    .i_frame_start (bFrameStart),
    .o_feat_ready  (bFeatReady),
    .o_frame_out   (bFrameOut),
    .o_frame_valid (bFrameValid),
    .o_frame_sat   (bFrameSat),
    .i_conv_done   (bConvDone),
    .o_frame_err   (bFrameErr),
    .o_busy        (bBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] slotOf(input int k);
    return frameOut[k*16 +: 16];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [23:0] value, input logic start);
    featIn     = value;
    frameStart = start;
    featValid  = 1'b1;
    tick();
    featValid  = 1'b0;
    frameStart = 1'b0;
  endtask

  task automatic releaseFrame();
    convDone = 1'b1;
    tick();
    convDone = 1'b0;
  endtask

  logic [23:0] satVec [4];
  logic [15:0] satExp [4];
  logic        satFlag[4];
  logic        seenReady;
  logic        seenErr;
  logic        seenValid;

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    featIn      = '0;
    featValid   = 1'b0;
    frameStart  = 1'b0;
    convDone    = 1'b0;
    bFeatIn     = '0;
    bFeatValid  = 1'b0;
    bFrameStart = 1'b0;
    bConvDone   = 1'b0;
    repeat (2) tick();

    checkOutput("reset_ready", 64'(featReady), 64'd1);
    checkOutput("reset_valid", 64'(frameValid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_frame_zero", 64'(|frameOut), 64'd0);
    rst_n = 1'b1;
    tick();

    // Nominal frame: k*256 lands as k in slot k.
    for (int k = 0; k < 40; k++) begin
      if (k == 39) checkOutput("nom_no_early_valid", 64'(frameValid), 64'd0);
      applyStimulus(24'(k * 256), k == 0);
    end
    checkOutput("nom_valid", 64'(frameValid), 64'd1);
    checkOutput("nom_ready_low", 64'(featReady), 64'd0);
    checkOutput("nom_busy", 64'(busy), 64'd1);
    checkOutput("nom_sat", 64'(frameSat), 64'd0);
    checkOutput("nom_err", 64'(frameErr), 64'd0);
    checkOutput("nom_slot0", 64'(slotOf(0)), 64'd0);
    checkOutput("nom_slot1", 64'(slotOf(1)), 64'd1);
    checkOutput("nom_slot20", 64'(slotOf(20)), 64'd20);
    checkOutput("nom_slot39", 64'(slotOf(39)), 64'd39);
    tick();
    checkOutput("nom_valid_pulse", 64'(frameValid), 64'd0);
    checkOutput("nom_wait_ready", 64'(featReady), 64'd0);
    releaseFrame();
    checkOutput("nom_ready_after_done", 64'(featReady), 64'd1);
    checkOutput("nom_idle_busy", 64'(busy), 64'd0);

    // Boundary values: 24 bits >>> 8 fits 16 bits exactly, so nothing clamps here.
    for (int k = 0; k < 40; k++) begin
      case (k)
        3:       applyStimulus(24'h7FFFFF, 1'b0);
        5:       applyStimulus(24'hFFFF00, 1'b0);
        7:       applyStimulus(24'h800000, 1'b0);
        9:       applyStimulus(24'h000180, 1'b0);
        11:      applyStimulus(24'hFFFE80, 1'b0);
        default: applyStimulus(24'(k * 256), k == 0);
      endcase
    end
    checkOutput("edge_valid", 64'(frameValid), 64'd1);
    checkOutput("edge_slot3", 64'(slotOf(3)), 64'h7FFF);
    checkOutput("edge_slot5", 64'(slotOf(5)), 64'hFFFF);
    checkOutput("edge_slot7", 64'(slotOf(7)), 64'h8000);
    checkOutput("edge_slot9", 64'(slotOf(9)), 64'h0001);
    checkOutput("edge_slot11", 64'(slotOf(11)), 64'hFFFE);
    checkOutput("edge_sat", 64'(frameSat), 64'd0);

    // Back-pressure: conv_done during ISSUE is ignored, feat_valid ignored while stalled.
    convDone   = 1'b1;
    featValid  = 1'b1;
    frameStart = 1'b1;
    featIn     = 24'h123400;
    tick();
    convDone = 1'b0;
    checkOutput("bp_issue_done_ignored", 64'(busy), 64'd1);
    checkOutput("bp_stalled_ready", 64'(featReady), 64'd0);
    seenReady = 1'b0;
    seenErr   = 1'b0;
    seenValid = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      seenReady = seenReady | featReady;
      seenErr   = seenErr | frameErr;
      seenValid = seenValid | frameValid;
    end
    checkOutput("bp_no_ready", 64'(seenReady), 64'd0);
    checkOutput("bp_no_err", 64'(seenErr), 64'd0);
    checkOutput("bp_no_valid", 64'(seenValid), 64'd0);
    checkOutput("bp_slot0_stable", 64'(slotOf(0)), 64'h0000);
    checkOutput("bp_slot3_stable", 64'(slotOf(3)), 64'h7FFF);
    featValid  = 1'b0;
    frameStart = 1'b0;
    releaseFrame();
    checkOutput("bp_ready_after_done", 64'(featReady), 64'd1);
    checkOutput("bp_slot0_not_taken", 64'(slotOf(0)), 64'h0000);

    // Restart after 10 coefficients abandons the partial frame.
    for (int k = 0; k < 10; k++) applyStimulus(24'(k * 256), k == 0);
    checkOutput("fe_no_err_yet", 64'(frameErr), 64'd0);
    applyStimulus(24'(100 * 256), 1'b1);
    checkOutput("fe_restart_err", 64'(frameErr), 64'd1);
    for (int k = 1; k < 40; k++) begin
      if (k == 2) checkOutput("fe_err_one_cycle", 64'(frameErr), 64'd0);
      if (k == 39) checkOutput("fe_no_early_valid", 64'(frameValid), 64'd0);
      applyStimulus(24'((k + 100) * 256), 1'b0);
    end
    checkOutput("fe_valid", 64'(frameValid), 64'd1);
    checkOutput("fe_slot0", 64'(slotOf(0)), 64'd100);
    checkOutput("fe_slot12", 64'(slotOf(12)), 64'd112);
    checkOutput("fe_slot39", 64'(slotOf(39)), 64'd139);
    tick();
    releaseFrame();
    applyStimulus(24'h00AB00, 1'b0);
    checkOutput("fe_drop_err", 64'(frameErr), 64'd1);
    checkOutput("fe_drop_slot0", 64'(slotOf(0)), 64'd100);
    tick();
    checkOutput("fe_drop_err_pulse", 64'(frameErr), 64'd0);

    // Bubbly input: random idle gaps between coefficients.
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      if (k == 39) checkOutput("bub_no_early_valid", 64'(frameValid), 64'd0);
      applyStimulus(24'((40 - k) * 256), k == 0);
    end
    checkOutput("bub_valid", 64'(frameValid), 64'd1);
    checkOutput("bub_slot0", 64'(slotOf(0)), 64'd40);
    checkOutput("bub_slot17", 64'(slotOf(17)), 64'd23);
    checkOutput("bub_slot39", 64'(slotOf(39)), 64'd1);
    tick();
    releaseFrame();

    // Reset at count 25, then a full fresh frame.
    for (int k = 0; k < 25; k++) applyStimulus(24'(k * 256 + 24'h5500), k == 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", 64'(featReady), 64'd1);
    checkOutput("mid_rst_frame_zero", 64'(|frameOut), 64'd0);
    checkOutput("mid_rst_sat", 64'(frameSat), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 40; k++) begin
      if (k == 39) checkOutput("rst_no_early_valid", 64'(frameValid), 64'd0);
      applyStimulus(24'((k + 7) * 256), k == 0);
    end
    checkOutput("rst_valid", 64'(frameValid), 64'd1);
    checkOutput("rst_slot24", 64'(slotOf(24)), 64'd31);
    checkOutput("rst_sat", 64'(frameSat), 64'd0);
    tick();
    releaseFrame();

    // Single-coefficient frames with SHIFT=4: saturation is reachable.
    satVec[0] = 24'h7FFFFF; satExp[0] = 16'h7FFF; satFlag[0] = 1'b1;
    satVec[1] = 24'h07FFF0; satExp[1] = 16'h7FFF; satFlag[1] = 1'b0;
    satVec[2] = 24'h800000; satExp[2] = 16'h8000; satFlag[2] = 1'b1;
    satVec[3] = 24'hFF8000; satExp[3] = 16'hF800; satFlag[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bFeatIn     = satVec[i];
      bFrameStart = 1'b1;
      bFeatValid  = 1'b1;
      tick();
      bFeatValid  = 1'b0;
      bFrameStart = 1'b0;
      checkOutput($sformatf("single_valid_%0d", i), 64'(bFrameValid), 64'd1);
      checkOutput($sformatf("single_value_%0d", i), 64'(bFrameOut), 64'(satExp[i]));
      checkOutput($sformatf("single_sat_%0d", i), 64'(bFrameSat), 64'(satFlag[i]));
      checkOutput($sformatf("single_err_%0d", i), 64'(bFrameErr), 64'd0);
      tick();
      bConvDone = 1'b1;
      tick();
      bConvDone = 1'b0;
      checkOutput($sformatf("single_ready_%0d", i), 64'(bFeatReady), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
